ring_counter_monitor: RTL and testbench

//  Receive-side checker for a one-hot right-rotating ring counter (MSB-first sequence).

---
 rtl/ring_pkg.sv | 24 ++
 rtl/ring_counter_monitor_if.sv | 27 ++
 rtl/ring_counter_monitor_onehot_to_bin.sv | 31 +++
 rtl/ring_counter_monitor.sv | 112 +++++++++++
 tb/tb_ring_counter_monitor.sv | 129 ++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring-counter monitor: FSM encoding, default width
// and the right-rotate helper used to predict the next ring word.
package ring_pkg;

  localparam int DEF_N = 4;
  localparam int MAX_N = 64;
  localparam int MAX_W = $clog2(MAX_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Rotates the low n bits of p right by one; bits at and above n come back zero
  // as long as the caller zero-extends its word.
  function automatic logic [MAX_N-1:0] rot_right(input logic [MAX_N-1:0] p, input int n);
    logic [MAX_N-1:0] r;
    r = p >> 1;
    r[MAX_W'(n - 1)] = p[0];
    return r;
  endfunction

endpackage

// File: rtl/ring_counter_monitor_if.sv
// Sample/status bundle between a ring-counter source and its monitor.
interface ring_counter_monitor_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     q_in;
  logic             in_valid;
  logic             clr_err;
  logic [IW-1:0]    idx;
  logic             onehot_ok;
  logic             locked;
  logic             step_err;
  logic             rev_pulse;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output q_in, in_valid, clr_err,
    input  idx, onehot_ok, locked, step_err, rev_pulse, err_cnt
  );

  modport slave (
    input  q_in, in_valid, clr_err,
    output idx, onehot_ok, locked, step_err, rev_pulse, err_cnt
  );
endinterface

// File: rtl/ring_counter_monitor_onehot_to_bin.sv
// Combinational one-hot decoder: set-bit position plus an exactly-one-bit flag.
// A word that is not one-hot decodes to index 0.
module onehot_to_bin #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  oh,
  output logic [IW-1:0] idx,
  output logic          is_onehot
);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] pop;
  logic [IW-1:0] enc;

  // OR-encoding is exact only when one bit is set; the flag gates it.
  always_comb begin
    pop = '0;
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) begin
        pop = pop + CW'(1);
        enc = enc | IW'(i);
      end
    end
  end

  assign is_onehot = (pop == CW'(1));
  assign idx       = is_onehot ? enc : '0;

endmodule

// File: rtl/ring_counter_monitor.sv
// Health monitor for a right-rotating one-hot ring counter: decodes each valid
// sample, tracks rotation lock, and reports breaks and full revolutions.
module ring_counter_monitor
  import ring_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ring_counter_monitor_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = $clog2(LOCK_CNT + 1);

  state_t           state, state_n;
  logic [MW-1:0]    match_cnt, match_cnt_n;
  logic [N-1:0]     prev, rot;
  logic [IW-1:0]    idx_c;
  logic             oh_c, match, step_n, rev_n;

  onehot_to_bin #(.N(N), .IW(IW)) u_dec (
    .oh        (bus.q_in),
    .idx       (idx_c),
    .is_onehot (oh_c)
  );

  // prev resets to zero, so rot is zero and cannot match until a real sample lands.
  assign rot   = N'(rot_right(MAX_N'(prev), N));
  assign match = oh_c && (bus.q_in == rot);

  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    step_n      = 1'b0;
    rev_n       = 1'b0;
    if (bus.in_valid) begin
      case (state)
        IDLE: begin
          if (oh_c) begin
            state_n     = TRACK;
            match_cnt_n = '0;
          end
        end
        TRACK: begin
          if (!oh_c) begin
            state_n     = IDLE;
            match_cnt_n = '0;
          end else if (match) begin
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state_n     = LOCKED;
              match_cnt_n = '0;
            end else begin
              match_cnt_n = match_cnt + MW'(1);
            end
          end else begin
            match_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            rev_n = bus.q_in[N-1];
          end else begin
            step_n      = 1'b1;
            match_cnt_n = '0;
            state_n     = oh_c ? TRACK : IDLE;
          end
        end
        default: begin
          state_n     = IDLE;
          match_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      match_cnt     <= '0;
      prev          <= '0;
      bus.idx       <= '0;
      bus.onehot_ok <= 1'b0;
      bus.locked    <= 1'b0;
      bus.step_err  <= 1'b0;
      bus.rev_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      match_cnt     <= match_cnt_n;
      bus.locked    <= (state_n == LOCKED);
      bus.step_err  <= step_n;
      bus.rev_pulse <= rev_n;
      if (bus.in_valid) begin
        prev          <= bus.q_in;
        bus.idx       <= idx_c;
        bus.onehot_ok <= oh_c;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.err_cnt <= '0;
    else if (bus.clr_err)
      bus.err_cnt <= '0;
    else if (step_n && (bus.err_cnt != {CNT_W{1'b1}}))
      bus.err_cnt <= bus.err_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Directed checks of the ring-counter monitor: lock-up, breaks, hold, saturation, async reset.
module tb_ring_counter_monitor;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ring_counter_monitor_if #(.N(4), .CNT_W(2)) bus ();

  ring_counter_monitor #(.N(4), .LOCK_CNT(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] q, input logic v, input logic c);
    bus.q_in     = q;
    bus.in_valid = v;
    bus.clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input int idx, input int ok, input int lk,
                      input int se, input int rp, input int ec);
    chk({tag, ".idx"},       32'(bus.idx),       32'(idx));
    chk({tag, ".onehot_ok"}, 32'(bus.onehot_ok), 32'(ok));
    chk({tag, ".locked"},    32'(bus.locked),    32'(lk));
    chk({tag, ".step_err"},  32'(bus.step_err),  32'(se));
    chk({tag, ".rev_pulse"}, 32'(bus.rev_pulse), 32'(rp));
    chk({tag, ".err_cnt"},   32'(bus.err_cnt),   32'(ec));
  endtask

  initial begin
    int ec;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.q_in = '0;
    bus.in_valid = 1'b0;
    bus.clr_err = 1'b0;
    #22;
    outs("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: lock-up and first revolution
    step(4'b1000, 1, 0); outs("t1_s0", 3, 1, 0, 0, 0, 0);
    step(4'b0100, 1, 0); outs("t1_s1", 2, 1, 0, 0, 0, 0);
    step(4'b0010, 1, 0); outs("t1_s2", 1, 1, 0, 0, 0, 0);
    step(4'b0001, 1, 0); outs("t1_s3", 0, 1, 1, 0, 0, 0);
    step(4'b1000, 1, 0); outs("t1_rev", 3, 1, 1, 0, 1, 0);
    step(4'b0000, 0, 0); outs("t1_revend", 3, 1, 1, 0, 0, 0);

    // 2: skipped position breaks lock, re-anchors in TRACK
    step(4'b0010, 1, 0); outs("t2_skip", 1, 1, 0, 1, 0, 1);
    step(4'b0001, 1, 0); outs("t2_r1", 0, 1, 0, 0, 0, 1);
    step(4'b1000, 1, 0); outs("t2_r2", 3, 1, 0, 0, 0, 1);
    step(4'b0100, 1, 0); outs("t2_r3", 2, 1, 1, 0, 0, 1);

    // 3: multi-hot while locked drops to IDLE; zero word then is quiet
    step(4'b1100, 1, 0); outs("t3_multi", 0, 0, 0, 1, 0, 2);
    step(4'b0000, 1, 0); outs("t3_zero", 0, 0, 0, 0, 0, 2);

    // 4: gaps in in_valid hold everything
    step(4'b1000, 1, 0);
    step(4'b0100, 1, 0);
    step(4'b0010, 1, 0);
    step(4'b0001, 1, 0); outs("t4_lock", 0, 1, 1, 0, 0, 2);
    step(4'b1111, 0, 0); outs("t4_hold0", 0, 1, 1, 0, 0, 2);
    step(4'b0101, 0, 0); outs("t4_hold1", 0, 1, 1, 0, 0, 2);
    step(4'b0000, 0, 0); outs("t4_hold2", 0, 1, 1, 0, 0, 2);
    step(4'b0010, 0, 0); outs("t4_hold3", 0, 1, 1, 0, 0, 2);
    step(4'b1000, 0, 0); outs("t4_hold4", 0, 1, 1, 0, 0, 2);
    step(4'b1000, 1, 0); outs("t4_resume", 3, 1, 1, 0, 1, 2);

    // 5: clear, then five breaks saturate the 2-bit counter
    step(4'b0000, 0, 1); outs("t5_clr", 3, 1, 1, 0, 0, 0);
    ec = 0;
    for (int i = 0; i < 5; i++) begin
      ec = (ec < 3) ? ec + 1 : 3;
      step(4'b1111, 1, 0); outs($sformatf("t5_err%0d", i), 0, 0, 0, 1, 0, ec);
      step(4'b1000, 1, 0);
      step(4'b0100, 1, 0);
      step(4'b0010, 1, 0);
      step(4'b0001, 1, 0);
    end
    chk("t5_relock", 32'(bus.locked), 32'd1);
    step(4'b1111, 1, 1); outs("t5_clr_err", 0, 0, 0, 1, 0, 0);

    // 6: async reset between edges while locked
    step(4'b1000, 1, 0);
    step(4'b0100, 1, 0);
    step(4'b0010, 1, 0);
    step(4'b0001, 1, 0);
    step(4'b1011, 1, 0); outs("t6_err", 0, 0, 0, 1, 0, 1);
    step(4'b0010, 1, 0);
    step(4'b0001, 1, 0);
    step(4'b1000, 1, 0);
    step(4'b0100, 1, 0); outs("t6_locked", 2, 1, 1, 0, 0, 1);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    outs("t6_async", 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    step(4'b0100, 1, 0); outs("t6_first", 2, 1, 0, 0, 0, 0);
    step(4'b0010, 1, 0); outs("t6_m1", 1, 1, 0, 0, 0, 0);
    step(4'b0001, 1, 0); outs("t6_m2", 0, 1, 0, 0, 0, 0);
    step(4'b1000, 1, 0); outs("t6_m3", 3, 1, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
